// File: rtl/canny_window_shifter.sv
// canny_window_shifter: turns a raster pixel stream into stacked 3-pixel row slices
// (ShiftA = row y-2, ShiftB = row y-1, ShiftC = row y) of the current 3x3 neighbourhood.
// Two line buffers hold the previous two rows. The window register is a single output stage
// with valid/ready flow control.
// Optional feature: define FRAME_SYNC_EN to add the sof input. A transfer with sof=1 is
// taken as pixel (0,0), and any partial frame is dropped without a frame_done pulse.
module canny_window_shifter #(
  parameter int IMGW = 768,
  parameter int IMGH = 1024,
  parameter int PIXW = 8,
  parameter int CNTW = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIXW-1:0]   pix_in,
  input  logic              pix_valid,
`ifdef FRAME_SYNC_EN
  input  logic              sof,
`endif
  output logic              pix_ready,
  output logic [3*PIXW-1:0] ShiftA,
  output logic [3*PIXW-1:0] ShiftB,
  output logic [3*PIXW-1:0] ShiftC,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              frame_done
);

  localparam int AW = (IMGW > 1) ? $clog2(IMGW) : 1;
  localparam logic [CNTW-1:0] COL_LAST = CNTW'(IMGW - 1);
  localparam logic [CNTW-1:0] ROW_LAST = CNTW'(IMGH - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_TWO  = CNTW'(2);

  // lb0 holds row y-2 and lb1 holds row y-1, both indexed by column. These buffers are not reset.
  logic [PIXW-1:0] lb0_q [IMGW];
  logic [PIXW-1:0] lb1_q [IMGW];

  logic [CNTW-1:0]   col_q, col_d, row_q, row_d;
  logic [CNTW-1:0]   col_cur, row_cur;
  logic [3*PIXW-1:0] sha_q, sha_d, shb_q, shb_d, shc_q, shc_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              in_xfer, win_xfer, row_start;
  logic [PIXW-1:0]   p1, p2;
  logic [AW-1:0]     lb_addr;

  assign pix_ready = !win_valid_q || win_ready;
  assign in_xfer   = pix_valid && pix_ready;
  assign win_xfer  = win_valid_q && win_ready;

  // Position of the incoming pixel. With frame sync enabled, sof forces this position to the origin.
  always_comb begin
    col_cur = col_q;
    row_cur = row_q;
`ifdef FRAME_SYNC_EN
    if (sof) begin
      col_cur = '0;
      row_cur = '0;
    end
`endif
  end

  assign lb_addr   = col_cur[AW-1:0];
  assign p1        = lb1_q[lb_addr];
  assign p2        = lb0_q[lb_addr];
  assign row_start = (col_cur == '0);

  // Next state of the counters, the slices and the window valid flag. Nothing changes while the window is stalled.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    sha_d        = sha_q;
    shb_d        = shb_q;
    shc_d        = shc_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;
    if (win_xfer) begin
      win_valid_d = 1'b0;
    end
    if (in_xfer) begin
      win_valid_d = (row_cur >= CNT_TWO) && (col_cur >= CNT_TWO);
      if (row_start) begin
        // Starting from zero means no window can mix pixels from two rows.
        sha_d = {{(2*PIXW){1'b0}}, p2};
        shb_d = {{(2*PIXW){1'b0}}, p1};
        shc_d = {{(2*PIXW){1'b0}}, pix_in};
      end else begin
        sha_d = {sha_q[2*PIXW-1:0], p2};
        shb_d = {shb_q[2*PIXW-1:0], p1};
        shc_d = {shc_q[2*PIXW-1:0], pix_in};
      end
      if (col_cur == COL_LAST) begin
        col_d = '0;
        if (row_cur == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_cur + CNT_ONE;
        end
      end else begin
        col_d = col_cur + CNT_ONE;
        row_d = row_cur;
      end
    end
  end

  // Control and window registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      sha_q        <= '0;
      shb_q        <= '0;
      shc_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      sha_q        <= sha_d;
      shb_q        <= shb_d;
      shc_q        <= shc_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Each line buffer is read before it is written at the same address. Every row moves down one buffer.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      lb0_q[lb_addr] <= p1;
      lb1_q[lb_addr] <= pix_in;
    end
  end

  assign ShiftA     = sha_q;
  assign ShiftB     = shb_q;
  assign ShiftC     = shc_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_canny_window_shifter.sv
// Testbench for canny_window_shifter. It uses an 8x6 image, a reference model built on a
// per-frame image array, and a window scoreboard queue.
module tb_canny_window_shifter;
  localparam int IMGW = 8;
  localparam int IMGH = 6;
  localparam int PIXW = 8;
  localparam int CNTW = 11;

  logic              clk;
  logic              reset;
  logic [PIXW-1:0]   pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic [3*PIXW-1:0] ShiftA, ShiftB, ShiftC;
  logic              win_valid;
  logic              win_ready;
  logic              frame_done;
`ifdef FRAME_SYNC_EN
  logic              sof;
`endif

  canny_window_shifter #(.IMGW(IMGW), .IMGH(IMGH), .PIXW(PIXW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
`ifdef FRAME_SYNC_EN
    .sof(sof),
`endif
    .pix_ready(pix_ready), .ShiftA(ShiftA), .ShiftB(ShiftB), .ShiftC(ShiftC),
    .win_valid(win_valid), .win_ready(win_ready), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  int n_fd = 0;
  int exp_fd = 0;
  int rdy_mode = 0;
  int m_col = 0;
  int m_row = 0;
  logic [7:0]  img [IMGH][IMGW];
  logic [71:0] exp_q[$];
  logic [71:0] got_q[$];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model. It stores the accepted pixel in the frame image and queues the 3x3 window ending at that pixel.
  task automatic model_accept(input logic [7:0] p, input bit s);
    logic [71:0] w;
    if (s) begin
      m_col = 0;
      m_row = 0;
    end
    img[m_row][m_col] = p;
    if (m_row >= 2 && m_col >= 2) begin
      w = '0;
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          w = {w[63:0], img[m_row-2+r][m_col-2+k]};
      exp_q.push_back(w);
    end
    m_col++;
    if (m_col == IMGW) begin
      m_col = 0;
      m_row++;
      if (m_row == IMGH) begin
        m_row = 0;
        exp_fd++;
      end
    end
  endtask

  task automatic send_pix(input logic [7:0] p, input bit s, input int gap);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (gap > 0 && $urandom_range(99) < gap) begin
      pix_valid = 1'b0;
      @(negedge clk);
    end
    pix_valid = 1'b1;
    pix_in = p;
`ifdef FRAME_SYNC_EN
    sof = s;
`endif
    #1;
    while (!pix_ready && waitc < 200) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    chk("pix_ready_timeout", 72'(pix_ready), 72'(1));
    if (pix_ready) model_accept(p, s);
    else pix_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit pattern, input int gap);
    logic [7:0] p;
    for (int i = 0; i < n; i++) begin
      p = pattern ? 8'(m_row * 16 + m_col) : 8'($urandom);
      send_pix(p, 1'b0, gap);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    @(negedge clk);
    pix_valid = 1'b0;
`ifdef FRAME_SYNC_EN
    sof = 1'b0;
`endif
    while ((exp_q.size() != 0 || win_valid) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("drain_queue_empty", 72'(exp_q.size()), 72'(0));
  endtask

  // Monitor. It drives win_ready and checks any window on display against the head of the
  // scoreboard. The head is popped when the window is taken.
  initial begin
    win_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       win_ready = 1'b1;
        1:       win_ready = 1'($urandom_range(1));
        default: win_ready = 1'b0;
      endcase
      #2;
      if (reset) begin
        if (frame_done) n_fd++;
        if (win_valid) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_window: got %h expected none", {ShiftA, ShiftB, ShiftC});
          end else begin
            chk("window", {ShiftA, ShiftB, ShiftC}, exp_q[0]);
            if (win_ready) begin
              got_q.push_back({ShiftA, ShiftB, ShiftC});
              void'(exp_q.pop_front());
            end
          end
          if (!win_ready) chk("pix_ready_stall", 72'(pix_ready), 72'(0));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ShiftA"}, 72'(ShiftA), 72'(0));
    chk({tag, "_ShiftB"}, 72'(ShiftB), 72'(0));
    chk({tag, "_ShiftC"}, 72'(ShiftC), 72'(0));
    chk({tag, "_win_valid"}, 72'(win_valid), 72'(0));
    chk({tag, "_frame_done"}, 72'(frame_done), 72'(0));
    chk({tag, "_pix_ready"}, 72'(pix_ready), 72'(1));
  endtask

  task automatic start_scenario();
    got_q.delete();
    n_fd = 0;
    exp_fd = 0;
  endtask

  localparam logic [71:0] FIRST_WIN = {24'h000102, 24'h101112, 24'h202122};

  initial begin
    reset = 1'b0;
    pix_valid = 1'b0;
    pix_in = '0;
`ifdef FRAME_SYNC_EN
    sof = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Full frame of pattern pixels, consumer always ready
    start_scenario();
    send_frame(IMGW * IMGH, 1'b1, 0);
    drain();
    chk("s1_window_count", 72'(got_q.size()), 72'(24));
    if (got_q.size() > 0) begin
      chk("s1_first_window", got_q[0], FIRST_WIN);
      chk("s1_last_A", 72'(got_q[got_q.size()-1][71:48]), 72'(24'h353637));
      chk("s1_last_C", 72'(got_q[got_q.size()-1][23:0]), 72'(24'h555657));
    end
    chk("s1_frame_done", 72'(n_fd), 72'(exp_fd));

    // Consumer stalls for 5 cycles in the middle of a frame
    start_scenario();
    fork
      send_frame(IMGW * IMGH, 1'b0, 0);
      begin : hold_blk
        int c;
        c = 0;
        while (got_q.size() < 5 && c < 500) begin
          @(negedge clk);
          c++;
        end
        #3 rdy_mode = 2;
        repeat (5) @(negedge clk);
        #3 rdy_mode = 0;
      end
    join
    drain();
    chk("s2_window_count", 72'(got_q.size()), 72'(24));
    chk("s2_frame_done", 72'(n_fd), 72'(exp_fd));

    // Two back-to-back frames of random data
    start_scenario();
    send_frame(2 * IMGW * IMGH, 1'b0, 0);
    drain();
    chk("s3_window_count", 72'(got_q.size()), 72'(48));
    chk("s3_frame_done", 72'(n_fd), 72'(2));

    // Reset mid-frame, then restart at (0,0)
    send_frame(3 * IMGW + 4, 1'b0, 0);
    drain();
    @(negedge clk);
    reset = 1'b0;
    #2;
    check_reset_outputs("midreset");
    m_col = 0;
    m_row = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start_scenario();
    send_frame(IMGW * IMGH, 1'b1, 0);
    drain();
    chk("s4_window_count", 72'(got_q.size()), 72'(24));
    if (got_q.size() > 0) chk("s4_first_window", got_q[0], FIRST_WIN);
    chk("s4_frame_done", 72'(n_fd), 72'(1));

    // Random input gaps and random consumer stalls
    start_scenario();
    rdy_mode = 1;
    send_frame(IMGW * IMGH, 1'b1, 50);
    #3 rdy_mode = 0;
    drain();
    chk("s5_window_count", 72'(got_q.size()), 72'(24));
    if (got_q.size() > 0) begin
      chk("s5_first_window", got_q[0], FIRST_WIN);
      chk("s5_last_A", 72'(got_q[got_q.size()-1][71:48]), 72'(24'h353637));
      chk("s5_last_C", 72'(got_q[got_q.size()-1][23:0]), 72'(24'h555657));
    end
    chk("s5_frame_done", 72'(n_fd), 72'(exp_fd));

`ifdef FRAME_SYNC_EN
    // sof at pixel (5,3) aborts the partial frame
    start_scenario();
    send_frame(3 * IMGW + 5, 1'b0, 0);
    drain();
    got_q.delete();
    send_pix(8'($urandom), 1'b1, 0);
    send_frame(IMGW * IMGH - 1, 1'b0, 0);
    drain();
    chk("s6_window_count", 72'(got_q.size()), 72'(24));
    chk("s6_frame_done", 72'(n_fd), 72'(1));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
